// File: rtl/tmds_video_sequencer.sv
// TMDS/DVI video timing sequencer: raster counters, pixel fetch and registered encoder control.
// Define TMDS_GUARD_BAND_EN to add HDMI video preambles and leading guard bands (needs H_BP >= 10).
module tmds_video_sequencer #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [23:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_req,
    output logic        o_de,
    output logic [2:0]  o_c0,
    output logic [2:0]  o_c1,
    output logic [7:0]  o_din0,
    output logic [7:0]  o_din1,
    output logic [7:0]  o_din2,
    output logic        o_gb_sel,
    output logic [9:0]  o_gb_word0,
    output logic [9:0]  o_gb_word1,
    output logic [9:0]  o_gb_word2,
    output logic [11:0] o_hcnt,
    output logic [11:0] o_vcnt,
    output logic        o_frame_start,
    output logic        o_underflow
);

    localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_LAST  = H_TOTAL - 12'd1;
    localparam logic [11:0] V_LAST  = V_TOTAL - 12'd1;
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [11:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic [23:0] pix_q;
    logic        h_last, v_last, running, active, hs_win, vs_win;

    assign h_last  = (hcnt == H_LAST);
    assign v_last  = (vcnt == V_LAST);
    assign running = (state != IDLE);
    assign active  = running && (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_win  = running && (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_win  = running && (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Next raster position decides the fetch strobe, so the pixel arrives one cycle ahead of its slot.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = RUN;
            RUN:     if (!i_en) state_nxt = DRAIN;
            DRAIN:   if (i_en) state_nxt = RUN;
                     else if (h_last && v_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        hcnt_nxt = 12'd0;
        vcnt_nxt = 12'd0;
        if (state == IDLE) begin
            if (state_nxt == RUN) begin
                hcnt_nxt = H_LAST;
                vcnt_nxt = V_LAST;
            end
        end else if (state_nxt != IDLE) begin
            hcnt_nxt = h_last ? 12'd0 : hcnt + 12'd1;
            vcnt_nxt = h_last ? (v_last ? 12'd0 : vcnt + 12'd1) : vcnt;
        end
        o_pix_req = running && (state_nxt != IDLE) && (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
    end

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [11:0] PRE_BEG = H_TOTAL - 12'd10;
    localparam logic [11:0] PRE_END = H_TOTAL - 12'd3;
    localparam logic [11:0] GB_BEG  = H_TOTAL - 12'd2;

    logic succ_active, pre_win, gb_win;

    // The last blanking line also precedes active video, via the frame wrap.
    assign succ_active = v_last || (vcnt < V_ACT - 12'd1);
    assign pre_win     = running && succ_active && (hcnt >= PRE_BEG) && (hcnt <= PRE_END);
    assign gb_win      = running && succ_active && (hcnt >= GB_BEG);
    assign o_gb_word0  = 10'b1011001100;
    assign o_gb_word1  = 10'b0100110011;
    assign o_gb_word2  = 10'b1011001100;
`else
    assign o_gb_word0  = 10'd0;
    assign o_gb_word1  = 10'd0;
    assign o_gb_word2  = 10'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hcnt          <= 12'd0;
            vcnt          <= 12'd0;
            pix_q         <= 24'd0;
            o_de          <= 1'b0;
            o_c0          <= {2'b00, ~HS_POL};
            o_c1          <= {2'b00, ~VS_POL};
            o_din0        <= 8'd0;
            o_din1        <= 8'd0;
            o_din2        <= 8'd0;
            o_gb_sel      <= 1'b0;
            o_hcnt        <= 12'd0;
            o_vcnt        <= 12'd0;
            o_frame_start <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
            if (o_pix_req) begin
                if (i_pix_valid) begin
                    pix_q <= i_pix_data;
                end else begin
                    pix_q       <= 24'd0;
                    o_underflow <= 1'b1;
                end
            end
            // Encoder side describes the position held in hcnt/vcnt during the previous cycle.
            o_de                   <= active;
            {o_din2, o_din1, o_din0} <= active ? pix_q : 24'd0;
            o_c0[0]                <= hs_win ? HS_POL : ~HS_POL;
            o_c1[0]                <= vs_win ? VS_POL : ~VS_POL;
            o_c1[2:1]              <= 2'b00;
`ifdef TMDS_GUARD_BAND_EN
            o_c0[2:1]              <= {1'b0, pre_win};
            o_gb_sel               <= gb_win;
`else
            o_c0[2:1]              <= 2'b00;
            o_gb_sel               <= 1'b0;
`endif
            o_hcnt                 <= hcnt;
            o_vcnt                 <= vcnt;
            o_frame_start          <= running && (hcnt == 12'd0) && (vcnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Bench for tmds_video_sequencer on a tiny 24x5 raster; pixel data checked through a scoreboard queue.
module tb_tmds_video_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_en = 1'b0;
    logic [23:0] i_pix_data = 24'd0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_req, o_de, o_gb_sel, o_frame_start, o_underflow;
    logic [2:0]  o_c0, o_c1;
    logic [7:0]  o_din0, o_din1, o_din2;
    logic [9:0]  o_gb_word0, o_gb_word1, o_gb_word2;
    logic [11:0] o_hcnt, o_vcnt;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int drop_at = 0;
    logic [23:0] sbq[$];

    tmds_video_sequencer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(12),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
        .o_pix_req(o_pix_req), .o_de(o_de), .o_c0(o_c0), .o_c1(o_c1),
        .o_din0(o_din0), .o_din1(o_din1), .o_din2(o_din2),
        .o_gb_sel(o_gb_sel), .o_gb_word0(o_gb_word0), .o_gb_word1(o_gb_word1), .o_gb_word2(o_gb_word2),
        .o_hcnt(o_hcnt), .o_vcnt(o_vcnt), .o_frame_start(o_frame_start), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    // Pixel source and scoreboard: push on each fetch strobe, pop on each o_de.
    initial begin : pixel_source
        logic [23:0] d, e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sbq.delete();
                i_pix_valid = 1'b0;
            end else begin
                checks++;
                if (o_de) begin
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_pixel: o_de with nothing expected at h=%0d v=%0d", o_hcnt, o_vcnt);
                    end else begin
                        e = sbq.pop_front();
                        if ({o_din2, o_din1, o_din0} !== e) begin
                            errors++;
                            $display("FAIL sb_pixel: got %h expected %h at h=%0d v=%0d",
                                     {o_din2, o_din1, o_din0}, e, o_hcnt, o_vcnt);
                        end
                    end
                end else if ({o_din2, o_din1, o_din0} !== 24'd0) begin
                    errors++;
                    $display("FAIL din_blank: got %h expected 0 at h=%0d v=%0d",
                             {o_din2, o_din1, o_din0}, o_hcnt, o_vcnt);
                end
                d = 24'($urandom);
                i_pix_data = d;
                if (o_pix_req) begin
                    req_cnt++;
                    if (req_cnt == drop_at) begin
                        i_pix_valid = 1'b0;
                        sbq.push_back(24'd0);
                    end else begin
                        i_pix_valid = 1'b1;
                        sbq.push_back(d);
                    end
                end else begin
                    i_pix_valid = 1'b0;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b expected 0", o_de); end
        checks++; if (o_pix_req !== 1'b0) begin errors++; $display("FAIL rst_pix_req: got %b expected 0", o_pix_req); end
        checks++; if (o_hcnt !== 12'd0 || o_vcnt !== 12'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", o_hcnt, o_vcnt); end
        checks++; if (o_c0 !== 3'b000 || o_c1 !== 3'b000) begin errors++; $display("FAIL rst_ctl: got c0=%b c1=%b expected 000/000", o_c0, o_c1); end
        checks++; if (o_gb_sel !== 1'b0 || o_frame_start !== 1'b0 || o_underflow !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got gb=%b fs=%b uf=%b expected 0", o_gb_sel, o_frame_start, o_underflow); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_de !== 1'b0 || o_pix_req !== 1'b0) begin errors++; $display("FAIL idle_hold: got de=%b req=%b expected 0", o_de, o_pix_req); end
    endtask

    task automatic test_startup;
        int k = 0;
        int n;
        @(negedge clk);
        i_en = 1'b1;
        for (int c = 1; c <= 10 && k == 0; c++) begin
            @(negedge clk);
            if (o_de) k = c;
        end
        checks++; if (k != 3) begin errors++; $display("FAIL first_de_latency: got %0d expected 3 cycles", k); end
        checks++; if (o_frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_first: got %b expected 1", o_frame_start); end
        checks++; if (o_hcnt !== 12'd0 || o_vcnt !== 12'd0) begin errors++; $display("FAIL first_pos: got %0d/%0d expected 0/0", o_hcnt, o_vcnt); end
        n = 1;
        for (int c = 1; c < 24; c++) begin
            @(negedge clk);
            if (o_de) n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL de_per_line: got %0d expected 8", n); end
        @(negedge clk);
        checks++; if (o_de !== 1'b1 || o_hcnt !== 12'd0 || o_vcnt !== 12'd1) begin
            errors++; $display("FAIL line_period: got de=%b h=%0d v=%0d expected 1/0/1", o_de, o_hcnt, o_vcnt); end
    endtask

    task automatic test_sync;
        logic       e_de, e_fs, succ, pre, gb;
        logic [2:0] e_c0, e_c1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            e_de = (o_hcnt < 8) && (o_vcnt < 2);
            e_fs = (o_hcnt == 0) && (o_vcnt == 0);
            succ = (o_vcnt == 4) || (o_vcnt == 0);
`ifdef TMDS_GUARD_BAND_EN
            pre  = succ && (o_hcnt >= 14) && (o_hcnt <= 21);
            gb   = succ && (o_hcnt >= 22);
`else
            pre  = 1'b0;
            gb   = 1'b0;
`endif
            e_c0 = {1'b0, pre, (o_hcnt >= 10) && (o_hcnt <= 11)};
            e_c1 = {2'b00, o_vcnt == 3};
            checks++; if (o_de !== e_de) begin errors++; $display("FAIL de_window: got %b expected %b at h=%0d v=%0d", o_de, e_de, o_hcnt, o_vcnt); end
            checks++; if (o_c0 !== e_c0) begin errors++; $display("FAIL c0_hsync_pre: got %b expected %b at h=%0d v=%0d", o_c0, e_c0, o_hcnt, o_vcnt); end
            checks++; if (o_c1 !== e_c1) begin errors++; $display("FAIL c1_vsync: got %b expected %b at h=%0d v=%0d", o_c1, e_c1, o_hcnt, o_vcnt); end
            checks++; if (o_gb_sel !== gb) begin errors++; $display("FAIL gb_sel: got %b expected %b at h=%0d v=%0d", o_gb_sel, gb, o_hcnt, o_vcnt); end
            checks++; if (o_frame_start !== e_fs) begin errors++; $display("FAIL frame_start: got %b expected %b at h=%0d v=%0d", o_frame_start, e_fs, o_hcnt, o_vcnt); end
`ifdef TMDS_GUARD_BAND_EN
            if (o_gb_sel) begin
                checks++;
                if (o_gb_word0 !== 10'b1011001100 || o_gb_word1 !== 10'b0100110011 || o_gb_word2 !== 10'b1011001100) begin
                    errors++; $display("FAIL gb_words: got %b %b %b", o_gb_word0, o_gb_word1, o_gb_word2); end
            end
`else
            checks++;
            if (o_gb_word0 !== 10'd0 || o_gb_word1 !== 10'd0 || o_gb_word2 !== 10'd0) begin
                errors++; $display("FAIL gb_words: got %b %b %b expected 0", o_gb_word0, o_gb_word1, o_gb_word2); end
`endif
        end
    endtask

    task automatic test_underflow;
        int c = 0;
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %b expected 0", o_underflow); end
        @(negedge clk);
        req_cnt = 0;
        drop_at = 3;
        while (req_cnt < 3 && c < 200) begin @(negedge clk); c++; end
        checks++; if (req_cnt < 3) begin errors++; $display("FAIL uf_wait: got %0d requests expected 3 within 200 cycles", req_cnt); end
        repeat (4) @(negedge clk);
        drop_at = 0;
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", o_underflow); end
        repeat (130) @(negedge clk);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", o_underflow); end
    endtask

    task automatic wait_row1_start(input string tag);
        int c = 0;
        while (!(o_de && o_hcnt == 12'd0 && o_vcnt == 12'd1) && c < 300) begin @(negedge clk); c++; end
        checks++; if (c >= 300) begin errors++; $display("FAIL %s_wait: got no pixel (0,1) expected within 300 cycles", tag); end
    endtask

    task automatic test_drain;
        int n_de = 0, n_fs = 0, n_req = 0;
        logic saw_last = 1'b0;
        wait_row1_start("drain");
        i_en = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_de) n_de++;
            if (o_frame_start) n_fs++;
            if (o_pix_req) n_req++;
            if (o_hcnt == 12'd23 && o_vcnt == 12'd4) saw_last = 1'b1;
        end
        checks++; if (n_de != 7) begin errors++; $display("FAIL drain_de: got %0d expected 7", n_de); end
        checks++; if (n_req != 5) begin errors++; $display("FAIL drain_req: got %0d expected 5", n_req); end
        checks++; if (n_fs != 0) begin errors++; $display("FAIL drain_fs: got %0d expected 0", n_fs); end
        checks++; if (saw_last !== 1'b1) begin errors++; $display("FAIL drain_complete: got %b expected 1", saw_last); end
        checks++; if (o_de !== 1'b0 || o_pix_req !== 1'b0 || o_hcnt !== 12'd0 || o_vcnt !== 12'd0) begin
            errors++; $display("FAIL drain_idle: got de=%b req=%b h=%0d v=%0d expected 0", o_de, o_pix_req, o_hcnt, o_vcnt); end
    endtask

    task automatic test_drain_resume;
        int gaps = 0, n_fs = 0, n_de = 0;
        logic [11:0] prev;
        i_en = 1'b1;
        wait_row1_start("resume");
        i_en = 1'b0;
        repeat (5) @(negedge clk);
        i_en = 1'b1;
        prev = o_hcnt;
        for (int c = 0; c < 240; c++) begin
            @(negedge clk);
            if (o_hcnt !== ((prev == 12'd23) ? 12'd0 : prev + 12'd1)) gaps++;
            if (o_frame_start) n_fs++;
            if (o_de) n_de++;
            prev = o_hcnt;
        end
        checks++; if (gaps != 0) begin errors++; $display("FAIL resume_gapless: got %0d breaks expected 0", gaps); end
        checks++; if (n_fs != 2) begin errors++; $display("FAIL resume_frames: got %0d expected 2", n_fs); end
        checks++; if (n_de != 32) begin errors++; $display("FAIL resume_de: got %0d expected 32", n_de); end
    endtask

    task automatic test_reset_mid;
        int c = 0;
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_pre_rst: got %b expected 1", o_underflow); end
        while (!o_de && c < 100) begin @(negedge clk); c++; end
        checks++; if (!o_de) begin errors++; $display("FAIL rstmid_wait: got de=0 expected 1 within 100 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (o_de !== 1'b0 || o_pix_req !== 1'b0 || o_frame_start !== 1'b0) begin
            errors++; $display("FAIL rstmid_de: got de=%b req=%b fs=%b expected 0", o_de, o_pix_req, o_frame_start); end
        checks++; if ({o_din2, o_din1, o_din0} !== 24'd0 || o_gb_sel !== 1'b0) begin
            errors++; $display("FAIL rstmid_data: got din=%h gb=%b expected 0", {o_din2, o_din1, o_din0}, o_gb_sel); end
        checks++; if (o_hcnt !== 12'd0 || o_vcnt !== 12'd0 || o_c0 !== 3'b000 || o_c1 !== 3'b000) begin
            errors++; $display("FAIL rstmid_pos: got h=%0d v=%0d c0=%b c1=%b expected 0", o_hcnt, o_vcnt, o_c0, o_c1); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL rstmid_uf: got %b expected 0", o_underflow); end
        i_en = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_startup;
        test_sync;
        test_underflow;
        test_drain;
        test_drain_resume;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
